ysyx_25060170_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32 core. It turns the IFU/IDU/EXU/GPR/WBU datapath from single-cycle into handshaked, memory-latency-tolerant operation.
- Issues instruction fetches and holds the fetched instruction stable for decode.
- Sequences the LSU access for loads and stores.
- Gates the GPR write and the PC update to a single writeback cycle per instruction.
- Supervises every wait state with a watchdog and counts retired instructions.

---
 rtl/ysyx_25060170_pkg.sv | 24 ++
 rtl/ysyx_25060170_seq_ctrl_if.sv | 23 ++
 rtl/ysyx_25060170_wdog.sv | 31 +++
 rtl/ysyx_25060170_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_ysyx_25060170_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25060170_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
package ysyx_25060170_pkg;

   localparam int unsigned INST_W    = 32;
   localparam int unsigned INSTRET_W = 32;
   localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FREQ  = 3'd1,
      S_FWAIT = 3'd2,
      S_EXEC  = 3'd3,
      S_MREQ  = 3'd4,
      S_MWAIT = 3'd5,
      S_WB    = 3'd6,
      S_STOP  = 3'd7
   } state_e;

   // States that depend on a memory handshake and are supervised by the watchdog.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FREQ) || (s == S_FWAIT) || (s == S_MREQ) || (s == S_MWAIT);
   endfunction

endpackage

// File: rtl/ysyx_25060170_seq_ctrl_if.sv
// Instruction-fetch and load/store handshake bundle between sequencer and memories.
interface ysyx_25060170_seq_ctrl_if;
   import ysyx_25060170_pkg::*;

   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic              ifu_rsp_valid;
   logic [INST_W-1:0] ifu_rsp_inst;
   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic              lsu_rsp_valid;

   modport master (
      output ifu_req_valid, lsu_req_valid,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, lsu_req_ready, lsu_rsp_valid
   );

   modport slave (
      input  ifu_req_valid, lsu_req_valid,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, lsu_req_ready, lsu_rsp_valid
   );

endinterface

// File: rtl/ysyx_25060170_wdog.sv
// Wait-state watchdog: counts cycles spent in one state, flags the MAX_WAIT-th cycle.
module ysyx_25060170_wdog #(
   parameter int unsigned MAX_WAIT = 255,
   parameter int unsigned WDOG_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   logic [WDOG_W-1:0] cnt_q, cnt_d;

   // cnt_q holds the cycles already completed, so the current cycle is number cnt_q+1.
   assign expired = count_en && (cnt_q == WDOG_W'(MAX_WAIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (count_en && !expired)
         cnt_d = cnt_q + WDOG_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ysyx_25060170_seq_ctrl.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with watchdog and retire counter.
// Optional ebreak halt enabled by defining SEQ_CTRL_EBREAK_HALT_EN.
module ysyx_25060170_seq_ctrl
   import ysyx_25060170_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255,
   parameter int unsigned WDOG_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ysyx_25060170_seq_ctrl_if.master bus,
   output logic [INST_W-1:0]    inst_o,
   input  logic                 is_load,
   input  logic                 is_store,
   input  logic                 is_ebreak,
   input  logic                 regw_i,
   output logic                 gpr_we_o,
   output logic                 pc_we_o,
   output logic                 retire_o,
   output logic [INSTRET_W-1:0] instret_o,
   output logic [2:0]           state_o,
   output logic                 err_o,
   output logic                 halted_o
);

   state_e                 state_q, state_d;
   logic [INST_W-1:0]      inst_q, inst_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;
   logic                   err_q, err_d;
   logic                   halted_q, halted_d;
   logic                   ifu_req_valid_q, ifu_req_valid_d;
   logic                   lsu_req_valid_q, lsu_req_valid_d;
   logic                   gpr_we_q, gpr_we_d;
   logic                   pc_we_q, pc_we_d;
   logic                   retire_q, retire_d;
   logic                   wd_clear, wd_count_en, wd_expired;

`ifndef SEQ_CTRL_EBREAK_HALT_EN
   logic unused_ebreak;
   assign unused_ebreak = is_ebreak;
`endif

   assign wd_count_en = is_wait_state(state_q);
   assign wd_clear    = (state_d != state_q);

   ysyx_25060170_wdog #(
      .MAX_WAIT (MAX_WAIT),
      .WDOG_W   (WDOG_W)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clear    (wd_clear),
      .count_en (wd_count_en),
      .expired  (wd_expired)
   );

   // Next state; a handshake always takes priority over a same-cycle timeout.
   always_comb begin
      state_d   = state_q;
      inst_d    = inst_q;
      instret_d = instret_q;
      err_d     = err_q;
      halted_d  = halted_q;
      case (state_q)
         S_IDLE:  state_d = S_FREQ;
         S_FREQ: begin
            if (bus.ifu_req_ready)  state_d = S_FWAIT;
            else if (wd_expired)    begin state_d = S_STOP; err_d = 1'b1; end
         end
         S_FWAIT: begin
            if (bus.ifu_rsp_valid)  begin state_d = S_EXEC; inst_d = bus.ifu_rsp_inst; end
            else if (wd_expired)    begin state_d = S_STOP; err_d = 1'b1; end
         end
         S_EXEC:  state_d = (is_load || is_store) ? S_MREQ : S_WB;
         S_MREQ: begin
            if (bus.lsu_req_ready)  state_d = S_MWAIT;
            else if (wd_expired)    begin state_d = S_STOP; err_d = 1'b1; end
         end
         S_MWAIT: begin
            if (bus.lsu_rsp_valid)  state_d = S_WB;
            else if (wd_expired)    begin state_d = S_STOP; err_d = 1'b1; end
         end
         S_WB: begin
            instret_d = instret_q + INSTRET_W'(1);
            state_d   = S_FREQ;
`ifdef SEQ_CTRL_EBREAK_HALT_EN
            if (is_ebreak) begin state_d = S_STOP; halted_d = 1'b1; end
`endif
         end
         S_STOP:  state_d = S_STOP;
         default: state_d = S_STOP;
      endcase

      // Outputs are flopped decodes of the next state so they line up with state_q.
      ifu_req_valid_d = (state_d == S_FREQ);
      lsu_req_valid_d = (state_d == S_MREQ);
      pc_we_d         = (state_d == S_WB);
      retire_d        = (state_d == S_WB);
      gpr_we_d        = (state_d == S_WB) && regw_i && !is_store;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         inst_q          <= INST_NOP;
         instret_q       <= '0;
         err_q           <= 1'b0;
         halted_q        <= 1'b0;
         ifu_req_valid_q <= 1'b0;
         lsu_req_valid_q <= 1'b0;
         gpr_we_q        <= 1'b0;
         pc_we_q         <= 1'b0;
         retire_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         inst_q          <= inst_d;
         instret_q       <= instret_d;
         err_q           <= err_d;
         halted_q        <= halted_d;
         ifu_req_valid_q <= ifu_req_valid_d;
         lsu_req_valid_q <= lsu_req_valid_d;
         gpr_we_q        <= gpr_we_d;
         pc_we_q         <= pc_we_d;
         retire_q        <= retire_d;
      end
   end

   assign bus.ifu_req_valid = ifu_req_valid_q;
   assign bus.lsu_req_valid = lsu_req_valid_q;
   assign inst_o            = inst_q;
   assign instret_o         = instret_q;
   assign state_o           = state_q;
   assign err_o             = err_q;
   assign halted_o          = halted_q;
   assign gpr_we_o          = gpr_we_q;
   assign pc_we_o           = pc_we_q;
   assign retire_o          = retire_q;

endmodule

// File: tb/tb_ysyx_25060170_seq_ctrl.sv
// Directed bench for the sequencer: memory responder with programmable latencies, MAX_WAIT=4.
module tb_ysyx_25060170_seq_ctrl;
   import ysyx_25060170_pkg::*;

   localparam logic [31:0] I_ADDI = 32'h0010_0093;
   localparam logic [31:0] I_LW   = 32'h0000_2103;
   localparam logic [31:0] I_SW   = 32'h0010_2023;
   localparam logic [31:0] I_EBRK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst_o, instret_o;
   logic [2:0]  state_o;
   logic        is_load, is_store, is_ebreak, regw_i;
   logic        gpr_we_o, pc_we_o, retire_o, err_o, halted_o;

   ysyx_25060170_seq_ctrl_if bus ();

   ysyx_25060170_seq_ctrl #(.MAX_WAIT(4), .WDOG_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .inst_o    (inst_o),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_ebreak (is_ebreak),
      .regw_i    (regw_i),
      .gpr_we_o  (gpr_we_o),
      .pc_we_o   (pc_we_o),
      .retire_o  (retire_o),
      .instret_o (instret_o),
      .state_o   (state_o),
      .err_o     (err_o),
      .halted_o  (halted_o)
   );

   always #5 clk = ~clk;

   // Minimal IDU: decode from the latched instruction; every non-ebreak op claims RegW.
   assign is_load   = (inst_o[6:0] == 7'b0000011);
   assign is_store  = (inst_o[6:0] == 7'b0100011);
   assign is_ebreak = (inst_o == I_EBRK);
   assign regw_i    = !is_ebreak;

   int          ifu_rdy_dly, ifu_rsp_dly, lsu_rdy_dly, lsu_rsp_dly;
   logic [31:0] fetch_inst;
   int          ireq, irsp, lreq, lrsp;
   int          n_pass, n_chk;

   // Memory responder: ready after N waiting cycles, response M cycles after the handshake.
   initial begin : mem_model
      ireq = 0; irsp = 0; lreq = 0; lrsp = 0;
      bus.ifu_req_ready = 1'b0; bus.ifu_rsp_valid = 1'b0; bus.ifu_rsp_inst = '0;
      bus.lsu_req_ready = 1'b0; bus.lsu_rsp_valid = 1'b0;
      forever begin
         @(negedge clk);
         bus.ifu_rsp_valid = 1'b0;
         if (irsp > 0) begin
            irsp--;
            if (irsp == 0) begin bus.ifu_rsp_valid = 1'b1; bus.ifu_rsp_inst = fetch_inst; end
         end
         bus.ifu_req_ready = 1'b0;
         if (bus.ifu_req_valid) begin
            if (ireq == ifu_rdy_dly) begin bus.ifu_req_ready = 1'b1; irsp = ifu_rsp_dly; ireq = 0; end
            else ireq++;
         end else ireq = 0;
         bus.lsu_rsp_valid = 1'b0;
         if (lrsp > 0) begin
            lrsp--;
            if (lrsp == 0) bus.lsu_rsp_valid = 1'b1;
         end
         bus.lsu_req_ready = 1'b0;
         if (bus.lsu_req_valid) begin
            if (lreq == lsu_rdy_dly) begin bus.lsu_req_ready = 1'b1; lrsp = lsu_rsp_dly; lreq = 0; end
            else lreq++;
         end else lreq = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Negedges until the next retire pulse (0 if none within the budget).
   task automatic wait_retire(output int n);
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (retire_o) begin n = k; break; end
      end
   endtask

   // Run one instruction to its retire, counting strobes seen on the way.
   task automatic run_insn(input logic [31:0] inst, output int lsu_cyc, output int gpr_cnt,
                           output int pc_cnt, output int ret_seen);
      fetch_inst = inst;
      lsu_cyc = 0; gpr_cnt = 0; pc_cnt = 0; ret_seen = 0;
      for (int k = 0; k < 40 && ret_seen == 0; k++) begin
         @(negedge clk);
         lsu_cyc += int'(bus.lsu_req_valid);
         gpr_cnt += int'(gpr_we_o);
         pc_cnt  += int'(pc_we_o);
         if (retire_o) ret_seen = 1;
      end
   endtask

   initial begin : main
      int exp_seq [6];
      int n, lc, gc, pc, rs, ifu_seen;
      int saw_stale, saw_fetch, saw_mem, bad_instret;
      n_pass = 0; n_chk = 0;
      exp_seq = '{0, 1, 2, 3, 6, 1};
      ifu_rdy_dly = 0; ifu_rsp_dly = 1; lsu_rdy_dly = 3; lsu_rsp_dly = 2;
      fetch_inst = I_ADDI;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_instret", instret_o, 32'd0);
      check("rst_inst", inst_o, INST_NOP);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_halted", 32'(halted_o), 32'd0);
      check("rst_ifu_valid", 32'(bus.ifu_req_valid), 32'd0);
      check("rst_lsu_valid", 32'(bus.lsu_req_valid), 32'd0);
      check("rst_strobes", {29'd0, pc_we_o, retire_o, gpr_we_o}, 32'd0);

      // Zero-wait ALU instructions: state walk and retire cadence
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("seq%0d", i), 32'(state_o), 32'(exp_seq[i]));
         if (i == 0) rst = 1'b0;
         if (i == 4) check("alu_wb_strobes", {29'd0, pc_we_o, retire_o, gpr_we_o}, 32'd7);
         if (i == 3) check("alu_no_strobe_exec", {29'd0, pc_we_o, retire_o, gpr_we_o}, 32'd0);
      end
      check("instret_after_1", instret_o, 32'd1);
      wait_retire(n);
      check("retire_period_a", 32'(n + 1), 32'd4);
      wait_retire(n);
      check("retire_period_b", 32'(n), 32'd4);
      @(negedge clk);
      check("instret_after_3", instret_o, 32'd3);

      // Load: ready after 3 wait cycles (hits the watchdog boundary), data 2 cycles later
      run_insn(I_LW, lc, gc, pc, rs);
      check("lw_retired", 32'(rs), 32'd1);
      check("lw_lsu_valid_cycles", 32'(lc), 32'd4);
      check("lw_gpr_we_pulses", 32'(gc), 32'd1);
      check("lw_pc_we_pulses", 32'(pc), 32'd1);
      check("lw_inst_latched", inst_o, I_LW);
      check("lw_no_err", 32'(err_o), 32'd0);

      // Store with RegW set: no GPR write
      run_insn(I_SW, lc, gc, pc, rs);
      check("sw_retired", 32'(rs), 32'd1);
      check("sw_lsu_valid_cycles", 32'(lc), 32'd4);
      check("sw_gpr_we_pulses", 32'(gc), 32'd0);
      check("sw_pc_we_pulses", 32'(pc), 32'd1);
      check("sw_instret_in_wb", instret_o, 32'd4);

      // Ebreak
      run_insn(I_EBRK, lc, gc, pc, rs);
      check("ebrk_retired", 32'(rs), 32'd1);
      check("ebrk_pc_we", 32'(pc), 32'd1);
      check("ebrk_no_lsu", 32'(lc), 32'd0);
      @(negedge clk);
      check("ebrk_instret", instret_o, 32'd6);
`ifdef SEQ_CTRL_EBREAK_HALT_EN
      check("ebrk_state_stop", 32'(state_o), 32'd7);
      check("ebrk_halted", 32'(halted_o), 32'd1);
      check("ebrk_err_clear", 32'(err_o), 32'd0);
      ifu_seen = 0;
      repeat (4) begin @(negedge clk); ifu_seen += int'(bus.ifu_req_valid); end
      check("ebrk_no_fetch", 32'(ifu_seen), 32'd0);
`else
      check("ebrk_keeps_fetching", 32'(bus.ifu_req_valid), 32'd1);
      check("ebrk_state_freq", 32'(state_o), 32'd1);
      check("ebrk_not_halted", 32'(halted_o), 32'd0);
`endif

      // Reset in MWAIT; the abandoned load's response lands while fetching
      ifu_rdy_dly = 2; lsu_rsp_dly = 4;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      fetch_inst = I_LW;
      for (int k = 0; k < 30 && state_o != 3'd5; k++) @(negedge clk);
      check("reach_mwait", 32'(state_o), 32'd5);
      fetch_inst = I_ADDI;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_state", 32'(state_o), 32'd0);
      check("mrst_inst_nop", inst_o, INST_NOP);
      check("mrst_lsu_valid", 32'(bus.lsu_req_valid), 32'd0);
      saw_stale = 0; saw_fetch = 0; saw_mem = 0; bad_instret = 0; rs = 0;
      for (int k = 0; k < 40 && rs == 0; k++) begin
         @(negedge clk);
         if (bus.lsu_rsp_valid && state_o == 3'd1) saw_stale = 1;
         if (bus.ifu_req_valid) saw_fetch = 1;
         if (state_o == 3'd4 || state_o == 3'd5) saw_mem = 1;
         if (instret_o != 32'd0) bad_instret = 1;
         if (retire_o) rs = 1;
      end
      check("mrst_stale_seen_in_freq", 32'(saw_stale), 32'd1);
      check("mrst_fetch_before_retire", 32'(saw_fetch), 32'd1);
      check("mrst_no_mem_state", 32'(saw_mem), 32'd0);
      check("mrst_instret_zero", 32'(bad_instret), 32'd0);
      check("mrst_retired", 32'(rs), 32'd1);
      check("mrst_inst", inst_o, I_ADDI);
      @(negedge clk);
      check("mrst_instret_one", instret_o, 32'd1);

      // Watchdog: fetch never accepted
      ifu_rdy_dly = 1000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int k = 0; k < 4; k++) begin @(negedge clk); n += int'(state_o == 3'd1); end
      check("wd_freq_cycles", 32'(n), 32'd4);
      @(negedge clk);
      check("wd_state_stop", 32'(state_o), 32'd7);
      check("wd_err", 32'(err_o), 32'd1);
      check("wd_ifu_valid_low", 32'(bus.ifu_req_valid), 32'd0);
      repeat (3) @(negedge clk);
      check("wd_err_sticky", 32'(err_o), 32'd1);
      check("wd_stop_outputs", {28'd0, bus.ifu_req_valid, bus.lsu_req_valid, pc_we_o, retire_o}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("wd_err_cleared", 32'(err_o), 32'd0);
      check("wd_state_idle", 32'(state_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
